// File: rtl/jump_sequencer.sv
// rtl/jump_sequencer.sv - sequences one JAL/JALR through the registered jump units
// Latches operands, resolves unit results, then writes back/redirects or traps.
module jump_sequencer #(
  parameter int RETIRE_COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          request_valid,
  output logic                          request_ready,
  input  logic                          request_is_jalr,
  input  logic [31:0]                   request_program_counter,
  input  logic [2:0]                    request_subfunction_3,
  input  logic [31:0]                   request_input_register1_value,
  input  logic [31:0]                   request_immediate,
  input  logic [4:0]                    request_rd_index,
  output logic [31:0]                   unit_program_counter,
  output logic [31:0]                   unit_input_register1_value,
  output logic [31:0]                   unit_immediate,
  output logic [2:0]                    unit_subfunction_3,
  input  logic [31:0]                   jal_result_rd,
  input  logic [31:0]                   jal_result_pc,
  input  logic [31:0]                   jalr_result_rd,
  input  logic [31:0]                   jalr_result_pc,
  output logic                          register_write_valid,
  input  logic                          register_write_ready,
  output logic [4:0]                    register_write_index,
  output logic [31:0]                   register_write_value,
  output logic                          pc_write_valid,
  output logic [31:0]                   pc_write_value,
  output logic                          pipeline_flush,
  output logic                          trap_valid,
  input  logic                          trap_ready,
  output logic [1:0]                    trap_cause,
  output logic [31:0]                   trap_program_counter,
  output logic [RETIRE_COUNT_WIDTH-1:0] retired_jump_count
);

  typedef enum logic [2:0] {
    IDLE, EXECUTE, RESOLVE, WRITEBACK, REDIRECT, TRAP
  } state_t;

  state_t state, next_state;

  logic                          is_jalr_q;
  logic [31:0]                   pc_q, rs1_q, imm_q, link_q, target_q;
  logic [2:0]                    funct3_q;
  logic [4:0]                    rd_q;
  logic [1:0]                    cause_q;
  logic [RETIRE_COUNT_WIDTH-1:0] count_q;

  logic [31:0] selected_target, selected_link;
  logic        illegal_funct3, misaligned_target;

  always_comb begin
    selected_target   = is_jalr_q ? jalr_result_pc : jal_result_pc;
    selected_link     = is_jalr_q ? jalr_result_rd : jal_result_rd;
    illegal_funct3    = is_jalr_q && (funct3_q != 3'b000);
    misaligned_target = (selected_target[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (request_valid) next_state = EXECUTE;
      EXECUTE:   next_state = RESOLVE;
      RESOLVE: begin
        // Illegal funct3 outranks misalignment; rd == 0 skips the register write.
        if (illegal_funct3 || misaligned_target) next_state = TRAP;
        else if (rd_q != 5'd0)                   next_state = WRITEBACK;
        else                                     next_state = REDIRECT;
      end
      WRITEBACK: if (register_write_ready) next_state = REDIRECT;
      REDIRECT:  next_state = IDLE;
      TRAP:      if (trap_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      is_jalr_q <= 1'b0;
      pc_q      <= '0;
      rs1_q     <= '0;
      imm_q     <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      link_q    <= '0;
      target_q  <= '0;
      cause_q   <= '0;
      count_q   <= '0;
    end else begin
      if (state == IDLE && request_valid) begin
        is_jalr_q <= request_is_jalr;
        pc_q      <= request_program_counter;
        rs1_q     <= request_input_register1_value;
        imm_q     <= request_immediate;
        funct3_q  <= request_subfunction_3;
        rd_q      <= request_rd_index;
      end
      // Capture the unit results once so the later handshakes see a frozen payload.
      if (state == RESOLVE) begin
        link_q   <= selected_link;
        target_q <= selected_target;
        cause_q  <= illegal_funct3 ? 2'd1 : 2'd2;
      end
      if (state == REDIRECT) count_q <= count_q + RETIRE_COUNT_WIDTH'(1);
    end
  end

  assign request_ready              = (state == IDLE);
  assign unit_program_counter       = pc_q;
  assign unit_input_register1_value = rs1_q;
  assign unit_immediate             = imm_q;
  assign unit_subfunction_3         = funct3_q;
  assign register_write_valid       = (state == WRITEBACK);
  assign register_write_index       = rd_q;
  assign register_write_value       = link_q;
  assign pc_write_valid             = (state == REDIRECT);
  assign pipeline_flush             = (state == REDIRECT);
  assign pc_write_value             = target_q;
  assign trap_valid                 = (state == TRAP);
  assign trap_cause                 = cause_q;
  assign trap_program_counter       = pc_q;
  assign retired_jump_count         = count_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// tb/tb_jump_sequencer.sv - self-checking bench for jump_sequencer
// Directed table, reset-abort sequence and random jumps against a reference model.
module tb_jump_sequencer;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        request_valid, request_ready, request_is_jalr;
  logic [31:0] request_program_counter, request_input_register1_value, request_immediate;
  logic [2:0]  request_subfunction_3;
  logic [4:0]  request_rd_index;
  logic [31:0] unit_program_counter, unit_input_register1_value, unit_immediate;
  logic [2:0]  unit_subfunction_3;
  logic [31:0] jal_result_rd, jal_result_pc, jalr_result_rd, jalr_result_pc;
  logic        register_write_valid, register_write_ready;
  logic [4:0]  register_write_index;
  logic [31:0] register_write_value;
  logic        pc_write_valid, pipeline_flush;
  logic [31:0] pc_write_value;
  logic        trap_valid, trap_ready;
  logic [1:0]  trap_cause;
  logic [31:0] trap_program_counter;
  logic [31:0] retired_jump_count;

  always #5 clk = ~clk;

  jump_sequencer #(.RETIRE_COUNT_WIDTH(32)) dut (
    .clk(clk), .n_reset(n_reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .request_is_jalr(request_is_jalr), .request_program_counter(request_program_counter),
    .request_subfunction_3(request_subfunction_3),
    .request_input_register1_value(request_input_register1_value),
    .request_immediate(request_immediate), .request_rd_index(request_rd_index),
    .unit_program_counter(unit_program_counter),
    .unit_input_register1_value(unit_input_register1_value),
    .unit_immediate(unit_immediate), .unit_subfunction_3(unit_subfunction_3),
    .jal_result_rd(jal_result_rd), .jal_result_pc(jal_result_pc),
    .jalr_result_rd(jalr_result_rd), .jalr_result_pc(jalr_result_pc),
    .register_write_valid(register_write_valid), .register_write_ready(register_write_ready),
    .register_write_index(register_write_index), .register_write_value(register_write_value),
    .pc_write_valid(pc_write_valid), .pc_write_value(pc_write_value),
    .pipeline_flush(pipeline_flush),
    .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_cause(trap_cause),
    .trap_program_counter(trap_program_counter),
    .retired_jump_count(retired_jump_count)
  );

  // Registered JAL / JALR execution units (JALR clears bit 0 of the target).
  always @(posedge clk) begin
    jal_result_pc  <= unit_program_counter + unit_immediate;
    jal_result_rd  <= unit_program_counter + 32'd4;
    jalr_result_pc <= (unit_input_register1_value + unit_immediate) & 32'hFFFF_FFFE;
    jalr_result_rd <= unit_program_counter + 32'd4;
  end

  typedef struct {
    logic        is_jalr;
    logic [31:0] pc, rs1, imm;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          wr_delay, trap_delay;
    logic [1:0]  exp_cause;   // 0 = no trap
    logic [31:0] exp_target, exp_link;
  } jump_t;

  int passed = 0, total = 0;
  logic [31:0] exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic jump_t model(input jump_t j);
    jump_t r = j;
    logic [31:0] t;
    t = j.is_jalr ? ((j.rs1 + j.imm) / 2) * 2 : j.pc + j.imm;
    r.exp_target = t;
    r.exp_link   = j.pc + 4;
    if (j.is_jalr && j.f3 != 0) r.exp_cause = 1;
    else if (t % 4 != 0)        r.exp_cause = 2;
    else                        r.exp_cause = 0;
    return r;
  endfunction

  task automatic run_jump(input jump_t j);
    int wb_first = -1, redirect_cycle = -1, trap_first = -1, done_cycle = -1;
    int wb_wait = 0, trap_wait = 0, pulses = 0, flush_bad = 0, unstable = 0, unit_bad = 0;
    logic [31:0] wb_val = 0, tr_pc = 0, tgt = 0;
    logic [4:0]  wb_idx = 0;
    logic [1:0]  tr_cause = 0;
    @(negedge clk);
    request_valid = 1'b1;
    request_is_jalr = j.is_jalr;
    request_program_counter = j.pc;
    request_input_register1_value = j.rs1;
    request_immediate = j.imm;
    request_subfunction_3 = j.f3;
    request_rd_index = j.rd;
    check("ready_before_accept", {31'd0, request_ready}, 32'd1);
    @(posedge clk);
    #1 request_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("ready_busy", {31'd0, request_ready}, 32'd0);
        if (unit_program_counter !== j.pc || unit_immediate !== j.imm ||
            unit_input_register1_value !== j.rs1 || unit_subfunction_3 !== j.f3) unit_bad++;
      end
      if (request_ready && c > 1) begin done_cycle = c; break; end
      if (pipeline_flush !== pc_write_valid) flush_bad++;
      if (pc_write_valid) begin
        pulses++;
        if (redirect_cycle < 0) begin redirect_cycle = c; tgt = pc_write_value; end
      end
      register_write_ready = 1'b0;
      trap_ready = 1'b0;
      if (register_write_valid) begin
        if (wb_first < 0) begin
          wb_first = c; wb_val = register_write_value; wb_idx = register_write_index;
        end else if (register_write_value !== wb_val || register_write_index !== wb_idx) unstable++;
        register_write_ready = (wb_wait >= j.wr_delay);
        wb_wait++;
      end
      if (trap_valid) begin
        if (trap_first < 0) begin
          trap_first = c; tr_cause = trap_cause; tr_pc = trap_program_counter;
        end else if (trap_cause !== tr_cause || trap_program_counter !== tr_pc) unstable++;
        trap_ready = (trap_wait >= j.trap_delay);
        trap_wait++;
      end
    end
    register_write_ready = 1'b0;
    trap_ready = 1'b0;
    check("unit_buses", unit_bad, 0);
    check("flush_matches_pc_write", flush_bad, 0);
    check("payload_stable", unstable, 0);
    if (j.exp_cause != 0) begin
      check("trap_cycle", trap_first, 3);
      check("trap_cause", {30'd0, tr_cause}, {30'd0, j.exp_cause});
      check("trap_pc", tr_pc, j.pc);
      check("trap_no_pc_write", pulses, 0);
      check("trap_no_reg_write", wb_first, -1);
      check("trap_done_cycle", done_cycle, 4 + j.trap_delay);
    end else begin
      check("no_trap", trap_first, -1);
      if (j.rd != 0) begin
        check("wb_cycle", wb_first, 3);
        check("wb_index", {27'd0, wb_idx}, {27'd0, j.rd});
        check("wb_value", wb_val, j.exp_link);
        check("redirect_cycle", redirect_cycle, 4 + j.wr_delay);
      end else begin
        check("rd0_no_reg_write", wb_first, -1);
        check("redirect_cycle", redirect_cycle, 3);
      end
      check("pc_write_pulses", pulses, 1);
      check("pc_write_value", tgt, j.exp_target);
      check("done_cycle", done_cycle, redirect_cycle + 1);
      exp_count++;
    end
    check("retired_count", retired_jump_count, exp_count);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'd0, request_ready}, 32'd1);
    check({tag, "_valids"}, {28'd0, register_write_valid, pc_write_valid, pipeline_flush, trap_valid}, 32'd0);
    check({tag, "_data"}, register_write_value | pc_write_value | trap_program_counter |
          unit_program_counter | unit_input_register1_value | unit_immediate |
          {27'd0, register_write_index} | {29'd0, unit_subfunction_3} | {30'd0, trap_cause}, 32'd0);
    check({tag, "_count"}, retired_jump_count, 32'd0);
  endtask

  jump_t table_v[8];

  initial begin
    int seen;
    n_reset = 1'b0;
    request_valid = 0; request_is_jalr = 0; request_program_counter = 0;
    request_input_register1_value = 0; request_immediate = 0;
    request_subfunction_3 = 0; request_rd_index = 0;
    register_write_ready = 0; trap_ready = 0;

    //           jalr pc            rs1            imm          f3 rd wd td cause target         link
    table_v[0] = '{1'b0, 32'h100,      32'h0,        32'h20, 3'd0, 5'd1, 0, 0, 2'd0, 32'h120,    32'h104};
    table_v[1] = '{1'b1, 32'h400,      32'h2001,     32'h3,  3'd0, 5'd0, 0, 0, 2'd0, 32'h2004,   32'h404};
    table_v[2] = '{1'b1, 32'h500,      32'h1000,     32'h2,  3'd0, 5'd3, 0, 2, 2'd2, 32'h1002,   32'h504};
    table_v[3] = '{1'b1, 32'h600,      32'h1000,     32'h2,  3'd1, 5'd4, 0, 0, 2'd1, 32'h1002,   32'h604};
    table_v[4] = '{1'b0, 32'h800,      32'h0,        32'h40, 3'd0, 5'd5, 3, 0, 2'd0, 32'h840,    32'h804};
    table_v[5] = '{1'b0, 32'hFFFFFFFC, 32'h0,        32'h8,  3'd0, 5'd7, 0, 0, 2'd0, 32'h4,      32'h0};
    table_v[6] = '{1'b0, 32'h10,       32'h0,        32'h2,  3'd0, 5'd1, 0, 1, 2'd2, 32'h12,     32'h14};
    table_v[7] = '{1'b1, 32'h20,       32'hFFFFFFFF, 32'h1,  3'd0, 5'd2, 1, 0, 2'd0, 32'h0,      32'h24};

    #12;
    check_all_zero("reset");
    @(negedge clk) n_reset = 1'b1;

    for (int i = 0; i < 8; i++) run_jump(table_v[i]);

    // Reset while WRITEBACK waits: abort without commit, then recover.
    @(negedge clk);
    request_valid = 1; request_is_jalr = 0; request_program_counter = 32'h900;
    request_immediate = 32'h10; request_rd_index = 5'd6; request_subfunction_3 = 0;
    register_write_ready = 0;
    @(posedge clk);
    #1 request_valid = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (register_write_valid) seen = 1;
    end
    check("reached_writeback", seen, 1);
    #2 n_reset = 1'b0;
    #1 check_all_zero("abort");
    exp_count = 0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (pc_write_valid) seen++;
    end
    check("abort_no_pc_write", seen, 0);
    n_reset = 1'b1;
    run_jump(table_v[0]);

    for (int n = 0; n < 40; n++) begin
      jump_t j;
      j.is_jalr    = 1'($urandom_range(0, 1));
      j.pc         = $urandom & 32'hFFFF_FFFC;
      j.rs1        = $urandom;
      j.imm        = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 255));
      j.f3         = $urandom_range(0, 3) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
      j.rd         = 5'($urandom_range(0, 31));
      j.wr_delay   = $urandom_range(0, 3);
      j.trap_delay = $urandom_range(0, 2);
      run_jump(model(j));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
